// File: rtl/dm_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word
  function automatic logic is_misaligned(input logic [2:0] dt, input logic [1:0] lane);
    case (dt[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return |lane;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Data SRAM port: ready-handshaked request from the controller to memory.
interface dm_access_ctrl_if #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32
);
  logic                 mem_req;
  logic [3:0]           mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_ready;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dm_lane_fmt.sv
// Combinational byte-lane formatter: store lane enables/replication and
// load byte/half selection with sign or zero extension.
module dm_lane_fmt
  import dm_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [2:0]           datatype,
  input  logic [1:0]           lane,
  input  logic [DATA_BITS-1:0] st_data,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [3:0]           be,
  output logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  assign w_byte   = mem_rdata[{lane, 3'b000} +: 8];
  assign w_half   = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  // BU/HU carry funct3[2]=1
  assign w_signed = ~datatype[2];

  always_comb begin
    be    = BE_W;
    wdata = st_data;
    ldata = mem_rdata;
    case (datatype[1:0])
      2'b00: begin
        be    = BE_B << lane;
        wdata = {(DATA_BITS/8){st_data[7:0]}};
        ldata = {{(DATA_BITS-8){w_signed & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        be    = lane[1] ? (BE_H << 2) : BE_H;
        wdata = {(DATA_BITS/16){st_data[15:0]}};
        ldata = {{(DATA_BITS-16){w_signed & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: turns EX/MEM loads/stores into
// SRAM transactions, stalls until done, flags misalignment and timeouts.
//
// state | meaning
// IDLE  | waiting for dm_rd/dm_wr; misaligned accesses skip straight to DONE
// BUSY  | mem_req held, counting cycles until mem_ready or TIMEOUT
// DONE  | result/pulse cycle; EX/MEM still holds the instruction, inputs ignored
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dm_rd,
  input  logic                 dm_wr,
  input  logic [2:0]           datatype,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] st_data,
  output logic                 stall,
  output logic                 ld_valid,
  output logic [DATA_BITS-1:0] ld_data,
  output logic                 misalign,
  output logic                 bus_err,
  dm_access_ctrl_if.master     mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_type;
  logic [1:0]           r_lane;
  logic                 r_is_load;
  logic                 r_req;
  logic [3:0]           r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic                 r_ld_valid;
  logic [DATA_BITS-1:0] r_ld_data;
  logic                 r_misalign;
  logic                 r_bus_err;

  logic                 w_access;
  logic                 w_misalign;
  logic [2:0]           w_fmt_type;
  logic [1:0]           w_fmt_lane;
  logic [3:0]           w_be;
  logic [DATA_BITS-1:0] w_wdata;
  logic [DATA_BITS-1:0] w_ldata;

  assign w_access   = dm_rd | dm_wr;
  assign w_misalign = is_misaligned(datatype, addr[1:0]);

  // Stores are formatted from live inputs in IDLE; loads from the latched lane/type.
  assign w_fmt_type = (r_state == IDLE) ? datatype  : r_type;
  assign w_fmt_lane = (r_state == IDLE) ? addr[1:0] : r_lane;

  dm_lane_fmt #(.DATA_BITS(DATA_BITS)) u_lane_fmt (
    .datatype  (w_fmt_type),
    .lane      (w_fmt_lane),
    .st_data   (st_data),
    .mem_rdata (mem.mem_rdata),
    .be        (w_be),
    .wdata     (w_wdata),
    .ldata     (w_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_type     <= '0;
      r_lane     <= '0;
      r_is_load  <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ld_valid <= 1'b0;
      r_ld_data  <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_type    <= datatype;
            r_lane    <= addr[1:0];
            r_is_load <= ~dm_wr;
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_req   <= 1'b1;
              r_addr  <= {addr[ADDR_BITS-1:2], 2'b00};
              r_we    <= dm_wr ? w_be : 4'b0000;
              r_wdata <= w_wdata;
              r_cnt   <= CNT_W'(1);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem.mem_ready) begin
            r_req   <= 1'b0;
            r_we    <= '0;
            r_state <= DONE;
            if (r_is_load) begin
              r_ld_data  <= w_ldata;
              r_ld_valid <= 1'b1;
            end
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_req     <= 1'b0;
            r_we      <= '0;
            r_ld_data <= '0;
            r_bus_err <= 1'b1;
            r_state   <= DONE;
          end else begin
            // timeout fires at TIMEOUT, so the counter can never wrap
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall         = ((r_state == IDLE) & w_access) | (r_state == BUSY);
  assign ld_valid      = r_ld_valid;
  assign ld_data       = r_ld_data;
  assign misalign      = r_misalign;
  assign bus_err       = r_bus_err;
  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios plus random
// loads/stores checked against a lane-arithmetic reference model.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dm_rd, dm_wr;
  logic [2:0]  datatype;
  logic [31:0] addr, st_data;
  logic        stall, ld_valid, misalign, bus_err;
  logic [31:0] ld_data;

  always #5 clk = ~clk;

  dm_access_ctrl_if #(.DATA_BITS(32), .ADDR_BITS(32)) mem_if ();

  dm_access_ctrl #(.DATA_BITS(32), .ADDR_BITS(32), .TIMEOUT(255)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dm_rd    (dm_rd),
    .dm_wr    (dm_wr),
    .datatype (datatype),
    .addr     (addr),
    .st_data  (st_data),
    .stall    (stall),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .misalign (misalign),
    .bus_err  (bus_err),
    .mem      (mem_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // observations captured by the transaction driver
  logic        o_stall_t, o_stall_all, o_req_seen, o_stable, o_done_stall;
  logic        o_ldv, o_mis, o_berr, o_post;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_we;
  int          o_done;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] dt);
    case (dt[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] dt, input logic [31:0] a);
    return (a % ref_size(dt)) != 0;
  endfunction

  function automatic logic [3:0] ref_we(input logic [2:0] dt, input logic [31:0] a);
    logic [3:0] we;
    int off, sz;
    we = 4'b0000;
    off = int'(a % 4);
    sz = ref_size(dt);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + sz) we[i] = 1'b1;
    return we;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] dt, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = ref_size(dt);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] dt, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = ref_size(dt);
    if (sz == 4) return rd;
    v = rd >> (8 * int'(a % 4));
    mask = 32'((64'd1 << (8 * sz)) - 64'd1);
    v = v & mask;
    if (!dt[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- transaction driver (no checks here) ----------------
  // Called and returning on a negedge. dly = cycles after t+1 before mem_ready; -1 never.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] dt,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int dly);
    dm_rd = rd; dm_wr = wr; datatype = dt; addr = a; st_data = sd;
    mem_if.mem_ready = 1'b0;
    #1 o_stall_t = stall;
    o_stall_all = 1'b1; o_req_seen = 1'b0; o_stable = 1'b1; o_done = -1;
    o_ldv = 1'b0; o_mis = 1'b0; o_berr = 1'b0; o_done_stall = 1'b0;
    o_addr = '0; o_we = '0; o_wdata = '0; o_ld = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      mem_if.mem_ready = 1'b0;
      mem_if.mem_rdata = $urandom;
      if (mem_if.mem_req) begin
        if (!o_req_seen) begin
          o_req_seen = 1'b1;
          o_addr = mem_if.mem_addr; o_we = mem_if.mem_we; o_wdata = mem_if.mem_wdata;
        end else if (mem_if.mem_addr !== o_addr || mem_if.mem_we !== o_we ||
                     mem_if.mem_wdata !== o_wdata) begin
          o_stable = 1'b0;
        end
        if (stall !== 1'b1) o_stall_all = 1'b0;
        if (c - 1 == dly) begin
          mem_if.mem_ready = 1'b1;
          mem_if.mem_rdata = rdata;
        end
      end else begin
        o_done = c;
        o_ldv = ld_valid; o_ld = ld_data; o_mis = misalign; o_berr = bus_err;
        o_done_stall = stall;
        break;
      end
    end
    dm_rd = 1'b0; dm_wr = 1'b0;
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    o_post = ld_valid | misalign | bus_err | mem_if.mem_req;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    dm_rd = 0; dm_wr = 0; datatype = 0; addr = 0; st_data = 0;
    mem_if.mem_ready = 0; mem_if.mem_rdata = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_if.mem_req, mem_if.mem_we, ld_valid, misalign, bus_err, stall} !== 9'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0",
        {mem_if.mem_req, mem_if.mem_we, ld_valid, misalign, bus_err, stall});
    end
    n_cmp++;
    if ({ld_data, mem_if.mem_addr, mem_if.mem_wdata} !== 96'b0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h want 0", ld_data, mem_if.mem_addr,
        mem_if.mem_wdata);
    end
    dm_rd = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL reset_stall_access: got %b want 1", stall); end
    dm_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sw();
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    n_cmp++;
    if (o_addr !== 32'h100 || o_we !== 4'b1111 || o_wdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL sw_bus: got %h %b %h want 00000100 1111 deadbeef", o_addr, o_we, o_wdata);
    end
    n_cmp++;
    if (!(o_stall_t && o_stall_all && !o_done_stall)) begin
      n_err++; $display("FAIL sw_stall: got %b%b%b want 110", o_stall_t, o_stall_all, o_done_stall);
    end
    n_cmp++;
    if (o_done !== 3) begin n_err++; $display("FAIL sw_done_cycle: got %0d want 3", o_done); end
    n_cmp++;
    if (o_ldv !== 1'b0 || o_post !== 1'b0) begin
      n_err++; $display("FAIL sw_pulses: got ldv=%b post=%b want 0 0", o_ldv, o_post);
    end
  endtask

  task automatic test_lb_lbu();
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0);
    n_cmp++;
    if (o_ldv !== 1'b1 || o_ld !== 32'hFFFFFF80) begin
      n_err++; $display("FAIL lb_sext: got v=%b %h want 1 ffffff80", o_ldv, o_ld);
    end
    n_cmp++;
    if (o_addr !== 32'h200 || o_we !== 4'b0000) begin
      n_err++; $display("FAIL lb_bus: got %h %b want 00000200 0000", o_addr, o_we);
    end
    run_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 2);
    n_cmp++;
    if (o_ldv !== 1'b1 || o_ld !== 32'h00000080) begin
      n_err++; $display("FAIL lbu_zext: got v=%b %h want 1 00000080", o_ldv, o_ld);
    end
    n_cmp++;
    if (o_done !== 4) begin n_err++; $display("FAIL lbu_done_cycle: got %0d want 4", o_done); end
  endtask

  task automatic test_sh();
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0);
    n_cmp++;
    if (o_addr !== 32'h100 || o_we !== 4'b1100 || o_wdata !== 32'hABCDABCD) begin
      n_err++; $display("FAIL sh_bus: got %h %b %h want 00000100 1100 abcdabcd", o_addr, o_we, o_wdata);
    end
  endtask

  task automatic test_misalign();
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    n_cmp++;
    if (o_done !== 1 || o_mis !== 1'b1 || o_req_seen !== 1'b0) begin
      n_err++; $display("FAIL lw_misalign: got done=%0d mis=%b req=%b want 1 1 0", o_done, o_mis, o_req_seen);
    end
    n_cmp++;
    if (o_stall_t !== 1'b1 || o_done_stall !== 1'b0 || o_post !== 1'b0) begin
      n_err++; $display("FAIL misalign_stall: got %b %b %b want 1 0 0", o_stall_t, o_done_stall, o_post);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, -1);
    n_cmp++;
    if (o_done !== 256 || o_berr !== 1'b1) begin
      n_err++; $display("FAIL timeout_cycle: got done=%0d berr=%b want 256 1", o_done, o_berr);
    end
    n_cmp++;
    if (o_ld !== 32'h0 || o_ldv !== 1'b0 || o_stable !== 1'b1 || o_stall_all !== 1'b1) begin
      n_err++; $display("FAIL timeout_data: got ld=%h v=%b stable=%b stall=%b want 0 0 1 1",
        o_ld, o_ldv, o_stable, o_stall_all);
    end
    // back-to-back access right after the timeout proves the FSM is in IDLE
    run_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h5A5A0F0F, 0);
    n_cmp++;
    if (o_stall_t !== 1'b1 || o_ld !== 32'h5A5A0F0F || o_done !== 2) begin
      n_err++; $display("FAIL after_timeout: got stall=%b ld=%h done=%0d want 1 5a5a0f0f 2",
        o_stall_t, o_ld, o_done);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    dm_rd = 1'b1; dm_wr = 1'b0; datatype = 3'b010; addr = 32'h40;
    @(negedge clk);
    n_cmp++;
    if (mem_if.mem_req !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", mem_if.mem_req); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 32'h0 || stall !== 1'b1) begin
      n_err++; $display("FAIL mid_reset: got req=%b addr=%h stall=%b want 0 0 1",
        mem_if.mem_req, mem_if.mem_addr, stall);
    end
    dm_rd = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL mid_reset_idle: got %b want 0", stall); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd = $urandom;
    run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rd, 2);
    n_cmp++;
    if (o_ld !== rd || o_ldv !== 1'b1 || o_done !== 4) begin
      n_err++; $display("FAIL post_reset_lw: got %h v=%b done=%0d want %h 1 4", o_ld, o_ldv, o_done, rd);
    end
  endtask

  task automatic test_random();
    logic [2:0]  dt;
    logic [31:0] a, sd, rd;
    logic        is_rd, is_wr, is_st;
    int          k, dly;
    logic [2:0]  ld_types [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL rnd_idle_stall: got %b want 0", stall); end
      end
      k = $urandom_range(0, 2);
      is_rd = (k != 1); is_wr = (k != 0); is_st = is_wr;
      dt = is_st ? ld_types[$urandom_range(0, 2)] : ld_types[$urandom_range(0, 4)];
      a = $urandom; sd = $urandom; rd = $urandom;
      dly = $urandom_range(0, 4);
      run_access(is_rd, is_wr, dt, a, sd, rd, dly);
      n_cmp++;
      if (o_stall_t !== 1'b1 || o_post !== 1'b0) begin
        n_err++; $display("FAIL rnd_stall_t: n=%0d got %b %b want 1 0", n, o_stall_t, o_post);
      end
      if (ref_mis(dt, a)) begin
        n_cmp++;
        if (o_done !== 1 || o_mis !== 1'b1 || o_req_seen !== 1'b0) begin
          n_err++; $display("FAIL rnd_misalign: n=%0d dt=%b a=%h got %0d %b %b want 1 1 0",
            n, dt, a, o_done, o_mis, o_req_seen);
        end
      end else begin
        n_cmp++;
        if (o_done !== dly + 2 || o_mis !== 1'b0 || o_berr !== 1'b0 || o_stable !== 1'b1 ||
            o_stall_all !== 1'b1 || o_done_stall !== 1'b0) begin
          n_err++; $display("FAIL rnd_flow: n=%0d got done=%0d mis=%b be=%b st=%b sa=%b ds=%b want %0d 0 0 1 1 0",
            n, o_done, o_mis, o_berr, o_stable, o_stall_all, o_done_stall, dly + 2);
        end
        n_cmp++;
        if (o_addr !== {a[31:2], 2'b00} || o_we !== (is_st ? ref_we(dt, a) : 4'b0000)) begin
          n_err++; $display("FAIL rnd_addr_we: n=%0d got %h %b want %h %b", n, o_addr, o_we,
            {a[31:2], 2'b00}, is_st ? ref_we(dt, a) : 4'b0000);
        end
        if (is_st) begin
          n_cmp++;
          if (o_wdata !== ref_wdata(dt, sd) || o_ldv !== 1'b0) begin
            n_err++; $display("FAIL rnd_wdata: n=%0d dt=%b got %h v=%b want %h 0", n, dt, o_wdata,
              o_ldv, ref_wdata(dt, sd));
          end
        end else begin
          n_cmp++;
          if (o_ld !== ref_load(dt, a, rd) || o_ldv !== 1'b1) begin
            n_err++; $display("FAIL rnd_load: n=%0d dt=%b a=%h rd=%h got %h v=%b want %h 1",
              n, dt, a, rd, o_ld, o_ldv, ref_load(dt, a, rd));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb_lbu();
    test_sh();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 500000", $time);
    $fatal(1);
  end

endmodule
